// File: rtl/upload_arb_pkg.sv
// Shared types and constants for the USB upload arbiter.
// No logic, no latency.
// No flow control of its own.
package upload_arb_pkg;

    // Arbiter is either waiting to grant or streaming one granted packet.
    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    // Upper nibble of the source-ID header byte.
    localparam logic [3:0] DEF_HDR_TAG = 4'hA;

    // The idle counter only needs to reach timeout-1; keep at least one bit.
    function automatic int to_cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/upload_arbiter_rr_pick.sv
// Round-robin pick: first requester at or above ptr, wrapping at NUM_SRC.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the pick is used.
module rr_pick #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [3:0]         ptr,
    output logic [3:0]         winner,
    output logic               any_req
);

    int   idx;
    logic found;
    logic sel;

    // Walk the sources starting at ptr and keep the first one requesting.
    always_comb begin
        winner = 4'd0;
        found  = 1'b0;
        idx    = 0;
        sel    = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            sel = 1'b0;
            for (int j = 0; j < NUM_SRC; j++) begin
                if (j == idx) begin
                    sel = req[j];
                end
            end
            if (!found && sel) begin
                found  = 1'b1;
                winner = 4'(idx);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/upload_arbiter.sv
// Packet-granular round-robin arbiter onto the single 8-bit USB upload stream.
// Header one cycle after grant, then one byte per cycle through one output register.
// Sink stall freezes the output register and drops src_ready; stalled sources time out.
module upload_arbiter
    import upload_arb_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter bit         HEADER_EN = 1'b1,
    parameter logic [3:0] HDR_TAG   = DEF_HDR_TAG,
    parameter int         TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_SRC*8-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [7:0]           up_data,
    output logic                 up_valid,
    input  logic                 up_ready,
    output logic                 busy,
    output logic [3:0]           grant_id,
    output logic                 err_timeout,
    output logic [7:0]           err_count
);

    localparam int            TW      = to_cnt_width(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    ptr;
    logic [3:0]    winner;
    logic          any_req;
    logic          out_free;
    logic          grant;
    logic          cur_valid;
    logic          cur_last;
    logic [7:0]    cur_data;
    logic          accept;
    logic          idle_beat;
    logic          timeout_hit;
    logic [TW-1:0] to_cnt;

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req     (src_valid),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign out_free    = !up_valid || up_ready;
    assign grant       = (state == IDLE) && enable && out_free && any_req;
    assign accept      = (state == DATA) && cur_valid && out_free;
    assign idle_beat   = (state == DATA) && !cur_valid;
    assign timeout_hit = (TIMEOUT != 0) && idle_beat && (to_cnt == TO_LAST);

    // Select the granted source's byte, valid and last.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == 4'(i)) begin
                cur_valid = src_valid[i];
                cur_last  = src_last[i];
                cur_data  = src_data[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: grant opens a packet; last beat or timeout closes it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant) state_nxt = DATA;
            DATA: if ((accept && cur_last) || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: only the granted source sees ready.
    always_comb begin
        busy      = (state == DATA);
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((state == DATA) && (grant_id == 4'(i))) begin
                src_ready[i] = out_free;
            end
        end
    end

    // Remember the winner and move the round-robin pointer past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id <= 4'd0;
            ptr      <= 4'd0;
        end else if (grant) begin
            grant_id <= winner;
            ptr      <= (winner == 4'(NUM_SRC - 1)) ? 4'd0 : winner + 4'd1;
        end
    end

    // Output register: header on grant, payload on accepted beat, else drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_valid <= 1'b0;
            up_data  <= 8'h00;
        end else if (out_free) begin
            if (grant && HEADER_EN) begin
                up_data  <= {HDR_TAG, winner};
                up_valid <= 1'b1;
            end else if (accept) begin
                up_data  <= cur_data;
                up_valid <= 1'b1;
            end else begin
                up_valid <= 1'b0;
            end
        end
    end

    // Count source-idle cycles inside a packet; sink stalls are not the source's fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (grant || accept || timeout_hit) begin
            to_cnt <= '0;
        end else if (idle_beat) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // Timeout pulse and saturating abort counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout <= 1'b0;
            err_count   <= 8'h00;
        end else begin
            err_timeout <= timeout_hit;
            if (timeout_hit && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_upload_arbiter.sv
`timescale 1ns/1ps
module tb_upload_arbiter;

    localparam int NS = 4;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [NS*8-1:0] src_data;
    logic [NS-1:0] src_valid;
    logic [NS-1:0] src_last;
    logic [NS-1:0] src_ready;
    logic [7:0]    up_data;
    logic          up_valid;
    logic          up_ready;
    logic          busy;
    logic [3:0]    grant_id;
    logic          err_timeout;
    logic [7:0]    err_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   to_pulses = 0;
    int   to_cyc    = 0;
    int   n_stall   = 0;
    bit   sb_off    = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    logic [8:0] sq[NS][$];
    logic [7:0] exp_q[$];
    int         xfer_cyc[$];

    upload_arbiter #(
        .NUM_SRC   (NS),
        .HEADER_EN (1'b1),
        .HDR_TAG   (4'hA),
        .TIMEOUT   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_last    (src_last),
        .src_ready   (src_ready),
        .up_data     (up_data),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout),
        .err_count   (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic src_push(input int s, input logic [7:0] d, input logic last);
        sq[s].push_back({last, d});
    endtask

    task automatic expect_byte(input logic [7:0] d);
        exp_q.push_back(d);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && !busy && !up_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s: not drained after %0d cycles, %0d bytes outstanding, busy=%0b",
                     name, budget, exp_q.size(), busy);
        end
    endtask

    task automatic wait_busy(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s: no grant within %0d cycles, busy=%0b", name, budget, busy);
        end
    endtask

    // Source models: present queue head, pop on the edge where valid&&ready was seen.
    initial begin : src_driver
        logic [NS-1:0] fire;
        logic [8:0]    head;
        forever begin
            @(negedge clk);
            fire = src_valid & src_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (fire[i] && sq[i].size() > 0) void'(sq[i].pop_front());
                if (sq[i].size() > 0) begin
                    head               = sq[i][0];
                    src_valid[i]       = 1'b1;
                    src_last[i]        = head[8];
                    src_data[8*i +: 8] = head[7:0];
                end else begin
                    src_valid[i]       = 1'b0;
                    src_last[i]        = 1'b0;
                    src_data[8*i +: 8] = 8'h00;
                end
            end
        end
    end

    // Monitor: scoreboard on every upload transfer, plus stall and timeout watching.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_data", {23'd0, up_valid, up_data}, {23'd0, 1'b1, prev_data});
            if (up_valid && !up_ready) begin
                n_stall++;
                check("stall_ready", {28'd0, src_ready}, 32'd0);
            end
            if (up_valid && up_ready && !sb_off) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected nothing (cycle %0d)", up_data, cyc);
                end else begin
                    check("up_data", {24'd0, up_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (err_timeout) begin
                to_pulses++;
                to_cyc = cyc;
            end
            prev_stall = up_valid && !up_ready;
            prev_data  = up_data;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [15:0] rdy_pat;
        int          viol;
        int          n;

        rst       = 1'b1;
        enable    = 1'b1;
        up_ready  = 1'b1;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_up_valid",  {31'd0, up_valid}, 32'd0);
        check("rst_up_data",   {24'd0, up_data}, 32'd0);
        check("rst_src_ready", {28'd0, src_ready}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_grant_id",  {28'd0, grant_id}, 32'd0);
        check("rst_err",       {23'd0, err_timeout, err_count}, 32'd0);
        tick();
        rst = 1'b0;

        // Fairness: all four request continuously, two 2-byte packets each.
        xfer_cyc.delete();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NS; i++) begin
                src_push(i, 8'(i*16 + k*2), 1'b0);
                src_push(i, 8'(i*16 + k*2 + 1), 1'b1);
                expect_byte(8'hA0 | 8'(i));
                expect_byte(8'(i*16 + k*2));
                expect_byte(8'(i*16 + k*2 + 1));
            end
        end
        wait_done("fairness", 200);
        for (int j = 0; j < 7; j++) begin
            check("fair_header_period",
                  (xfer_cyc.size() >= 24) ? xfer_cyc[3*j+3] - xfer_cyc[3*j] : -1, 3);
        end
        check("fair_last_grant", {28'd0, grant_id}, 32'd3);

        // Single source: src1 three bytes, header immediately followed by payload.
        xfer_cyc.delete();
        src_push(1, 8'h11, 1'b0);
        src_push(1, 8'h22, 1'b0);
        src_push(1, 8'h33, 1'b1);
        expect_byte(8'hA1);
        expect_byte(8'h11);
        expect_byte(8'h22);
        expect_byte(8'h33);
        wait_done("single", 50);
        check("single_consecutive", (xfer_cyc.size() >= 4) ? xfer_cyc[3] - xfer_cyc[0] : -1, 3);
        check("single_busy_after", {31'd0, busy}, 32'd0);

        // Backpressure: stalls of 2 and 10 cycles; a long stall must not time out.
        n_stall = 0;
        src_push(2, 8'h51, 1'b0);
        src_push(2, 8'h52, 1'b0);
        src_push(2, 8'h53, 1'b0);
        src_push(2, 8'h54, 1'b1);
        expect_byte(8'hA2);
        expect_byte(8'h51);
        expect_byte(8'h52);
        expect_byte(8'h53);
        expect_byte(8'h54);
        rdy_pat = 16'b1100_0000_0000_1001;
        for (int c = 0; c < 16; c++) begin
            tick();
            up_ready = rdy_pat[c];
        end
        tick();
        up_ready = 1'b1;
        wait_done("backpressure", 50);
        check("bp_stalls_seen", (n_stall >= 10) ? 1 : 0, 1);
        check("bp_no_timeout", {24'd0, err_count}, 32'd0);
        check("bp_no_pulse", to_pulses, 0);

        // Timeout: src2 sends one byte without last, then goes quiet.
        xfer_cyc.delete();
        src_push(2, 8'h77, 1'b0);
        expect_byte(8'hA2);
        expect_byte(8'h77);
        n = 0;
        @(negedge clk);
        while (to_pulses == 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_pulse_seen", (to_pulses > 0) ? 1 : 0, 1);
        check("to_latency", (xfer_cyc.size() >= 2) ? to_cyc - xfer_cyc[1] : -1, 8);
        repeat (3) @(negedge clk);
        check("to_single_pulse", to_pulses, 1);
        check("to_err_count", {24'd0, err_count}, 32'd1);
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_drained", exp_q.size(), 0);
        src_push(3, 8'h3C, 1'b1);
        expect_byte(8'hA3);
        expect_byte(8'h3C);
        wait_done("after_timeout", 50);

        // Enable: drop it inside a src0 packet; src1 waits until re-enabled.
        for (int b = 0; b < 4; b++) src_push(0, 8'h61 + 8'(b), (b == 3));
        src_push(1, 8'h71, 1'b0);
        src_push(1, 8'h72, 1'b1);
        expect_byte(8'hA0);
        for (int b = 0; b < 4; b++) expect_byte(8'h61 + 8'(b));
        expect_byte(8'hA1);
        expect_byte(8'h71);
        expect_byte(8'h72);
        wait_busy("en_grant", 20);
        tick();
        enable = 1'b0;
        n = 0;
        @(negedge clk);
        while (exp_q.size() > 3 && n < 30) begin
            @(negedge clk);
            n++;
        end
        viol = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy || up_valid) viol++;
        end
        check("en_no_grant", viol, 0);
        check("en_pending", exp_q.size(), 3);
        tick();
        enable = 1'b1;
        wait_done("en_resume", 50);

        // Reset mid-packet, then all four request: first grant must be src0.
        sb_off = 1'b1;
        for (int b = 0; b < 6; b++) src_push(2, 8'h81 + 8'(b), (b == 5));
        wait_busy("rst_grant", 20);
        repeat (2) @(negedge clk);
        tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < NS; i++) sq[i].delete();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_up_valid",  {31'd0, up_valid}, 32'd0);
        check("mid_rst_src_ready", {28'd0, src_ready}, 32'd0);
        check("mid_rst_busy",      {31'd0, busy}, 32'd0);
        check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
        tick();
        rst    = 1'b0;
        sb_off = 1'b0;
        for (int i = 0; i < NS; i++) begin
            src_push(i, 8'h90 + 8'(i), 1'b1);
            expect_byte(8'hA0 | 8'(i));
            expect_byte(8'h90 + 8'(i));
        end
        wait_done("post_reset", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
